mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage that sits directly downstream of the execute stage and directly upstream of write-back. It takes the registered execute-stage results, performs at most one word load or store per instruction on a request/grant/response data-memory port, and stalls the pipeline until the access completes. It then registers the write-back bundle (integer or float destination, rd address, data) for the register files.

## Interface
- TIMEOUT_CYCLES, 255: the stage abandons an access after this many wait cycles in REQ or RESP; range 1..65535.
- CLK  in  1  clock.
- RST_N  in  1  reset, synchronous, active-low.
- Flush_ex  in  1  the instruction in the EX/MEM register is squashed; no access, no write-back.
- Load_ex, F_inst_ex  in  1  load flag and FP-instruction flag from EX/MEM.
- RE_ex, WE_ex  in  1  memory read or write request (word).
- WE_reg_ex, WE_freg_ex  in  1  integer or float register write enables.
- rd_addr_ex  in  5  destination register.
- mem_addr_ex  in  32  byte address.
- exe_result_ex  in  32  ALU result or link value.
- op2_ex  in  32  store data.
- dmem_req  out  1  access request; held until dmem_gnt.
- dmem_we  out  1  1 = store.
- dmem_addr  out  32  word-aligned address.
- dmem_wdata  out  32  store data.
- dmem_gnt  in  1  request accepted this cycle.
- dmem_rvalid  in  1  load data valid this cycle.
- dmem_rdata  in  32  load data.
- Stall_mem  out  1  freezes PC/IF/ID/EX and the EX/MEM register this cycle.
- WE_reg_mem, WE_freg_mem  out  1  write-back enables.
- F_inst_mem  out  1  registered F_inst_ex.
- rd_addr_mem  out  5  write-back rd.
- wb_data_mem  out  32  write-back data.
- misalign_err  out  1  one-cycle pulse on a misaligned access.
- mem_err  out  1  sticky timeout flag.

## Operation
- An access is defined as acc = (RE_ex | WE_ex) & ~Flush_ex & (mem_addr_ex[1:0] == 0).
- A misaligned access (RE_ex | WE_ex, ~Flush_ex, mem_addr_ex[1:0] != 0):
  - no request is issued;
  - misalign_err pulses the next cycle;
  - write-back enables are forced to 0;
  - the access is treated as complete with no stall.
- FSM states: IDLE, REQ, RESP.
  - IDLE: dmem_req = acc & RST_N.
    - acc & dmem_gnt & WE_ex: store done, stay in IDLE.
    - acc & dmem_gnt & RE_ex: go to RESP.
    - acc & ~dmem_gnt: go to REQ.
  - REQ: dmem_req = 1, with address, we and wdata driven from the held EX/MEM inputs.
    - On gnt, a store goes to IDLE (done) and a load goes to RESP.
  - RESP: dmem_req = 0. On dmem_rvalid, the load is done and the FSM goes to IDLE.
- Stall_mem = ~done, where done means the current instruction completes this cycle:
  - no access;
  - store granted this cycle;
  - dmem_rvalid in RESP;
  - or timeout.
- dmem_rvalid is ignored in IDLE and REQ (a late response after a timeout or reset is dropped).
- Wait counter:
  - clears on entry to REQ or RESP;
  - increments each cycle spent in REQ or RESP;
  - when it reaches TIMEOUT_CYCLES, mem_err is set (sticky until reset), the FSM returns to IDLE, the instruction completes with write-back suppressed, and Stall_mem drops that cycle.
- If RE_ex and WE_ex are both set, the store wins (dmem_we = 1) and no write-back of load data occurs.
- MEM/WB register:
  - On a done cycle: WE_reg_mem/WE_freg_mem = WE_*_ex & ~Flush_ex & ~error, F_inst_mem = F_inst_ex, rd_addr_mem = rd_addr_ex, wb_data_mem = Load_ex ? dmem_rdata : exe_result_ex.
  - On a stall cycle: a bubble is loaded (both WE = 0; other fields hold).
- Reset:
  - all outputs and registers are 0, the FSM is in IDLE, and the counter is 0;
  - mem_err is cleared only by reset;
  - a reset asserted mid-access drops dmem_req in that same cycle, and the outstanding response is ignored.

## Timing
- A store granted in the same cycle as it is presented adds 0 stall cycles. Write-back registers are updated at the next edge.
- Load latency: with gnt in the presentation cycle and rvalid k ≥ 1 cycles later, Stall_mem is high for k cycles. wb_data_mem is valid on the edge after rvalid.
- Each grant-wait cycle adds 1 stall cycle.
- dmem_addr, dmem_we and dmem_wdata are stable while dmem_req = 1, because the upstream stage is frozen by Stall_mem.
- misalign_err and the mem_err set are registered, so both appear 1 cycle after the triggering cycle.
- Stall_mem is combinational from state and the dmem_* inputs. There is no combinational path from dmem_rdata to Stall_mem.

## Test plan
- Reset: hold RST_N = 0 for 3 cycles with RE_ex = 1 → dmem_req = 0 throughout; all outputs are 0 after release.
- Zero-wait store: WE_ex = 1, addr 0x100, op2 0xDEADBEEF, gnt in the same cycle → dmem_req = 1 for one cycle with we = 1, Stall_mem = 0, and the next cycle WE_reg_mem = 0.
- Load with wait: RE_ex = 1, addr 0x204, rd = 5, WE_reg_ex = 1, gnt after 2 cycles, rvalid 3 cycles after gnt with 0x12345678 → Stall_mem is high for 5 cycles, then WE_reg_mem = 1, rd_addr_mem = 5, wb_data_mem = 0x12345678.
- ALU passthrough and flush: an ALU op with result 0x55 and WE_freg_ex = 1 gives WE_freg_mem = 1 and wb_data_mem = 0x55. The same op with Flush_ex = 1 gives both WE = 0 and no dmem_req.
- Misaligned: RE_ex = 1 with addr 0x102 → no dmem_req, a misalign_err pulse, WE_reg_mem = 0, and Stall_mem = 0.
- Timeout: TIMEOUT_CYCLES = 4 with gnt never asserted → Stall_mem is high for 4 cycles, mem_err = 1 and stays sticky, write-back is suppressed, and a later rvalid is ignored.

Source files
------------

// File: rtl/mem_stage_if.sv
// Data-memory request/grant/response port between the MEM stage and the data memory.
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  // Pipeline side issues requests, memory side grants and responds.
  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_gnt,
    input  dmem_rvalid,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_gnt,
    output dmem_rvalid,
    output dmem_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: one word load/store per instruction, stalls
// the front of the pipe until the access completes, registers the WB bundle.
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        Flush_ex,
  input  logic        Load_ex,
  input  logic        F_inst_ex,
  input  logic        RE_ex,
  input  logic        WE_ex,
  input  logic        WE_reg_ex,
  input  logic        WE_freg_ex,
  input  logic [4:0]  rd_addr_ex,
  input  logic [31:0] mem_addr_ex,
  input  logic [31:0] exe_result_ex,
  input  logic [31:0] op2_ex,
  mem_stage_if.master dmem,
  output logic        Stall_mem,
  output logic        WE_reg_mem,
  output logic        WE_freg_mem,
  output logic        F_inst_mem,
  output logic [4:0]  rd_addr_mem,
  output logic [31:0] wb_data_mem,
  output logic        misalign_err,
  output logic        mem_err
);

  localparam int unsigned CNT_W = 16;
  // Last wait-counter value before the access is abandoned.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;

  logic any_rw;
  logic aligned;
  logic acc;
  logic misal;
  logic at_limit;
  logic done;
  logic tmo;
  logic req;
  logic wb_err;
  logic load_wb;

  // Access decode, completion and timeout detection for the current cycle.
  always_comb begin
    any_rw   = (RE_ex | WE_ex) & ~Flush_ex;
    aligned  = (mem_addr_ex[1:0] == 2'b00);
    acc      = any_rw & aligned;
    misal    = any_rw & ~aligned & (state == IDLE);
    at_limit = (wait_cnt == CNT_LAST);
    done     = 1'b1;
    tmo      = 1'b0;
    req      = 1'b0;
    case (state)
      IDLE: begin
        req  = acc;
        done = ~acc | (dmem.dmem_gnt & WE_ex);
      end
      REQ: begin
        req = 1'b1;
        if (dmem.dmem_gnt) begin
          done = WE_ex;
        end else begin
          tmo  = at_limit;
          done = at_limit;
        end
      end
      RESP: begin
        if (!dmem.dmem_rvalid) begin
          tmo  = at_limit;
          done = at_limit;
        end
      end
      default: begin
        done = 1'b1;
      end
    endcase
    wb_err  = misal | tmo;
    load_wb = Load_ex & ~WE_ex;
  end

  // Request side of the port; reset kills the request in the same cycle.
  assign dmem.dmem_req   = req & RST_N;
  assign dmem.dmem_we    = WE_ex;
  assign dmem.dmem_addr  = {mem_addr_ex[31:2], 2'b00};
  assign dmem.dmem_wdata = op2_ex;
  assign Stall_mem       = RST_N & ~done;

  // Access FSM and wait counter.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (acc && !(dmem.dmem_gnt && WE_ex)) begin
            state    <= dmem.dmem_gnt ? RESP : REQ;
            wait_cnt <= '0;
          end
        end
        REQ: begin
          if (dmem.dmem_gnt) begin
            state    <= WE_ex ? IDLE : RESP;
            wait_cnt <= '0;
          end else if (at_limit) begin
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (dmem.dmem_rvalid || at_limit) begin
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: begin
          state    <= IDLE;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  // MEM/WB register plus error flags; a bubble is loaded while stalled.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      WE_reg_mem   <= 1'b0;
      WE_freg_mem  <= 1'b0;
      F_inst_mem   <= 1'b0;
      rd_addr_mem  <= '0;
      wb_data_mem  <= '0;
      misalign_err <= 1'b0;
      mem_err      <= 1'b0;
    end else begin
      misalign_err <= misal;
      mem_err      <= mem_err | tmo;
      if (done) begin
        WE_reg_mem  <= WE_reg_ex & ~Flush_ex & ~wb_err;
        WE_freg_mem <= WE_freg_ex & ~Flush_ex & ~wb_err;
        F_inst_mem  <= F_inst_ex;
        rd_addr_mem <= rd_addr_ex;
        wb_data_mem <= load_wb ? dmem.dmem_rdata : exe_result_ex;
      end else begin
        WE_reg_mem  <= 1'b0;
        WE_freg_mem <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized
// instructions compared against a latency/write-back model built from delays.
module tb_mem_stage;

  localparam int TMO = 4;

  typedef struct {
    logic        re, we, ld, fi, wer, wef, flush;
    logic [4:0]  rd;
    logic [31:0] addr, exe, op2, rdata;
    int          g;   // cycle index (0 = presentation) at which gnt is driven
    int          rv;  // cycle index at which rvalid is driven, -1 = never
  } ins_t;

  typedef struct {
    int          stalls, reqs;
    bit          bus_bad;
    logic        we_reg, we_freg, f_inst, mis, merr;
    logic [4:0]  rd;
    logic [31:0] data;
  } obs_t;

  logic CLK = 1'b0;
  logic RST_N;
  logic Flush_ex, Load_ex, F_inst_ex, RE_ex, WE_ex, WE_reg_ex, WE_freg_ex;
  logic [4:0]  rd_addr_ex;
  logic [31:0] mem_addr_ex, exe_result_ex, op2_ex;
  logic Stall_mem, WE_reg_mem, WE_freg_mem, F_inst_mem, misalign_err, mem_err;
  logic [4:0]  rd_addr_mem;
  logic [31:0] wb_data_mem;

  int   n_cmp = 0;
  int   n_err = 0;
  logic exp_merr = 1'b0;

  mem_stage_if dmem_bus ();

  mem_stage #(.TIMEOUT_CYCLES(TMO)) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .Flush_ex      (Flush_ex),
    .Load_ex       (Load_ex),
    .F_inst_ex     (F_inst_ex),
    .RE_ex         (RE_ex),
    .WE_ex         (WE_ex),
    .WE_reg_ex     (WE_reg_ex),
    .WE_freg_ex    (WE_freg_ex),
    .rd_addr_ex    (rd_addr_ex),
    .mem_addr_ex   (mem_addr_ex),
    .exe_result_ex (exe_result_ex),
    .op2_ex        (op2_ex),
    .dmem          (dmem_bus),
    .Stall_mem     (Stall_mem),
    .WE_reg_mem    (WE_reg_mem),
    .WE_freg_mem   (WE_freg_mem),
    .F_inst_mem    (F_inst_mem),
    .rd_addr_mem   (rd_addr_mem),
    .wb_data_mem   (wb_data_mem),
    .misalign_err  (misalign_err),
    .mem_err       (mem_err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic ins_t blank();
    ins_t b;
    b.re = 0; b.we = 0; b.ld = 0; b.fi = 0; b.wer = 0; b.wef = 0; b.flush = 0;
    b.rd = '0; b.addr = '0; b.exe = '0; b.op2 = '0; b.rdata = '0;
    b.g = 0; b.rv = -1;
    return b;
  endfunction

  // Reference: stall count from grant/response delays, WB from the done cycle.
  function automatic obs_t model(input ins_t in);
    obs_t e;
    bit   any, acc, tmo;
    int   k;
    any = (in.re | in.we) & ~in.flush;
    acc = any && (in.addr[1:0] == 2'b00);
    e.mis = any & ~acc;
    tmo = 0;
    k = in.rv - in.g;
    if (!acc)                     e.stalls = 0;
    else if (in.g > TMO)          begin e.stalls = TMO; tmo = 1; end
    else if (in.we)               e.stalls = in.g;
    else if (in.rv < 0 || k > TMO) begin e.stalls = in.g + TMO; tmo = 1; end
    else                          e.stalls = in.g + k;
    e.reqs    = acc ? (((in.g > TMO) ? TMO : in.g) + 1) : 0;
    e.bus_bad = 0;
    e.we_reg  = in.wer & ~in.flush & ~e.mis & ~tmo;
    e.we_freg = in.wef & ~in.flush & ~e.mis & ~tmo;
    e.f_inst  = in.fi;
    e.rd      = in.rd;
    e.data    = (in.ld & ~in.we) ? in.rdata : in.exe;
    e.merr    = exp_merr | tmo;
    return e;
  endfunction

  task automatic drive_nop();
    Flush_ex = 0; Load_ex = 0; F_inst_ex = 0; RE_ex = 0; WE_ex = 0;
    WE_reg_ex = 0; WE_freg_ex = 0; rd_addr_ex = '0; mem_addr_ex = '0;
    exe_result_ex = '0; op2_ex = '0;
    dmem_bus.dmem_gnt = 0; dmem_bus.dmem_rvalid = 0;
  endtask

  // Presents one instruction (entered just after a rising edge), plays the
  // memory's gnt/rvalid schedule and collects what the stage did.
  task automatic run_instr(input ins_t in, output obs_t o);
    o.stalls = 0; o.reqs = 0; o.bus_bad = 0;
    RE_ex = in.re; WE_ex = in.we; Load_ex = in.ld; F_inst_ex = in.fi;
    WE_reg_ex = in.wer; WE_freg_ex = in.wef; Flush_ex = in.flush;
    rd_addr_ex = in.rd; mem_addr_ex = in.addr; exe_result_ex = in.exe; op2_ex = in.op2;
    for (int c = 0; c < 40; c++) begin
      dmem_bus.dmem_gnt    = (c == in.g);
      dmem_bus.dmem_rvalid = (c == in.rv);
      dmem_bus.dmem_rdata  = in.rdata;
      @(negedge CLK);
      if (dmem_bus.dmem_req === 1'b1) begin
        o.reqs++;
        if (dmem_bus.dmem_we !== in.we || dmem_bus.dmem_addr !== {in.addr[31:2], 2'b00} ||
            (in.we && dmem_bus.dmem_wdata !== in.op2))
          o.bus_bad = 1;
      end
      if (Stall_mem === 1'b0) break;
      o.stalls++;
      @(posedge CLK); #1;
    end
    @(posedge CLK); #1;
    drive_nop();
    @(negedge CLK);
    o.we_reg = WE_reg_mem; o.we_freg = WE_freg_mem; o.f_inst = F_inst_mem;
    o.rd = rd_addr_mem; o.data = wb_data_mem; o.mis = misalign_err; o.merr = mem_err;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    drive_nop();
    RST_N = 0; RE_ex = 1; Load_ex = 1; mem_addr_ex = 32'h40;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      n_cmp++;
      if (dmem_bus.dmem_req !== 1'b0 || Stall_mem !== 1'b0) begin
        n_err++;
        $display("FAIL reset_req_stall cyc%0d: got req=%b stall=%b expected 0/0", i, dmem_bus.dmem_req, Stall_mem);
      end
      @(posedge CLK);
    end
    #1;
    drive_nop();
    RST_N = 1;
    @(negedge CLK);
    n_cmp++;
    if ({Stall_mem, WE_reg_mem, WE_freg_mem, F_inst_mem, misalign_err, mem_err, dmem_bus.dmem_req} !== 7'b0 ||
        rd_addr_mem !== 5'd0 || wb_data_mem !== 32'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got flags=%b rd=%0d data=%h expected all 0",
               {Stall_mem, WE_reg_mem, WE_freg_mem, F_inst_mem, misalign_err, mem_err, dmem_bus.dmem_req},
               rd_addr_mem, wb_data_mem);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_store();
    ins_t in; obs_t o;
    in = blank(); in.we = 1; in.addr = 32'h100; in.op2 = 32'hDEADBEEF; in.g = 0;
    run_instr(in, o);
    n_cmp++; if (o.stalls !== 0) begin n_err++; $display("FAIL store_stall: got %0d expected 0", o.stalls); end
    n_cmp++; if (o.reqs !== 1) begin n_err++; $display("FAIL store_req_cycles: got %0d expected 1", o.reqs); end
    n_cmp++; if (o.bus_bad !== 0) begin n_err++; $display("FAIL store_bus: got bad=%0d expected 0", o.bus_bad); end
    n_cmp++; if (o.we_reg !== 1'b0) begin n_err++; $display("FAIL store_we_reg: got %b expected 0", o.we_reg); end
  endtask

  task automatic test_load_wait();
    ins_t in; obs_t o;
    in = blank(); in.re = 1; in.ld = 1; in.wer = 1; in.rd = 5'd5; in.addr = 32'h204;
    in.g = 2; in.rv = 5; in.rdata = 32'h12345678;
    run_instr(in, o);
    n_cmp++; if (o.stalls !== 5) begin n_err++; $display("FAIL load_stall: got %0d expected 5", o.stalls); end
    n_cmp++; if (o.reqs !== 3) begin n_err++; $display("FAIL load_req_cycles: got %0d expected 3", o.reqs); end
    n_cmp++;
    if (o.we_reg !== 1'b1 || o.rd !== 5'd5 || o.data !== 32'h12345678) begin
      n_err++; $display("FAIL load_wb: got we=%b rd=%0d data=%h expected 1/5/12345678", o.we_reg, o.rd, o.data);
    end
  endtask

  task automatic test_alu_flush();
    ins_t in; obs_t o;
    in = blank(); in.wef = 1; in.fi = 1; in.exe = 32'h55; in.rd = 5'd9;
    run_instr(in, o);
    n_cmp++;
    if (o.we_freg !== 1'b1 || o.we_reg !== 1'b0 || o.data !== 32'h55 || o.f_inst !== 1'b1) begin
      n_err++; $display("FAIL alu_pass: got wef=%b wer=%b data=%h fi=%b expected 1/0/55/1", o.we_freg, o.we_reg, o.data, o.f_inst);
    end
    in.flush = 1; in.re = 1; in.ld = 1; in.addr = 32'h300;
    run_instr(in, o);
    n_cmp++;
    if (o.we_freg !== 1'b0 || o.we_reg !== 1'b0 || o.reqs !== 0 || o.stalls !== 0) begin
      n_err++; $display("FAIL alu_flush: got wef=%b wer=%b reqs=%0d stalls=%0d expected 0/0/0/0", o.we_freg, o.we_reg, o.reqs, o.stalls);
    end
  endtask

  task automatic test_misaligned();
    ins_t in; obs_t o;
    in = blank(); in.re = 1; in.ld = 1; in.wer = 1; in.addr = 32'h102; in.g = 0; in.rv = 1;
    run_instr(in, o);
    n_cmp++;
    if (o.reqs !== 0 || o.stalls !== 0) begin
      n_err++; $display("FAIL misalign_access: got reqs=%0d stalls=%0d expected 0/0", o.reqs, o.stalls);
    end
    n_cmp++; if (o.mis !== 1'b1) begin n_err++; $display("FAIL misalign_pulse: got %b expected 1", o.mis); end
    n_cmp++; if (o.we_reg !== 1'b0) begin n_err++; $display("FAIL misalign_we: got %b expected 0", o.we_reg); end
    @(negedge CLK);
    n_cmp++; if (misalign_err !== 1'b0) begin n_err++; $display("FAIL misalign_one_cycle: got %b expected 0", misalign_err); end
    @(posedge CLK); #1;
  endtask

  task automatic test_timeout();
    ins_t in; obs_t o;
    n_cmp++; if (mem_err !== 1'b0) begin n_err++; $display("FAIL merr_before: got %b expected 0", mem_err); end
    in = blank(); in.re = 1; in.ld = 1; in.wer = 1; in.rd = 5'd7; in.addr = 32'h80; in.g = 99;
    run_instr(in, o);
    n_cmp++; if (o.stalls !== TMO) begin n_err++; $display("FAIL tmo_stall: got %0d expected %0d", o.stalls, TMO); end
    n_cmp++; if (o.merr !== 1'b1) begin n_err++; $display("FAIL tmo_merr: got %b expected 1", o.merr); end
    n_cmp++; if (o.we_reg !== 1'b0) begin n_err++; $display("FAIL tmo_we: got %b expected 0", o.we_reg); end
    exp_merr = 1'b1;
    // Late response arriving while an ALU op sits in the stage is dropped.
    in = blank(); in.wer = 1; in.exe = 32'h77; in.rd = 5'd2; in.rv = 0; in.rdata = 32'hBAD0BAD0;
    run_instr(in, o);
    n_cmp++;
    if (o.stalls !== 0 || o.data !== 32'h77 || o.we_reg !== 1'b1) begin
      n_err++; $display("FAIL late_rvalid: got stalls=%0d data=%h we=%b expected 0/77/1", o.stalls, o.data, o.we_reg);
    end
    n_cmp++; if (o.merr !== 1'b1) begin n_err++; $display("FAIL merr_sticky: got %b expected 1", o.merr); end
  endtask

  task automatic test_random();
    ins_t in; obs_t o, e;
    for (int n = 0; n < 60; n++) begin
      in = blank();
      in.rd = 5'($urandom); in.fi = 1'($urandom); in.exe = $urandom; in.op2 = $urandom;
      in.rdata = $urandom; in.addr = {30'($urandom), 2'b00};
      in.g = int'($urandom_range(0, 6));
      in.rv = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : -1;
      case ($urandom_range(0, 4))
        0: begin in.we = 1; in.wer = 1'($urandom); end
        1: begin
          in.re = 1; in.ld = 1; in.wer = 1'($urandom); in.wef = ~in.wer;
          in.rv = in.g + int'($urandom_range(1, 6));
        end
        2: begin in.wer = 1'($urandom); in.wef = 1'($urandom); end
        3: begin
          in.re = 1'($urandom); in.we = ~in.re; in.ld = in.re; in.wer = 1;
          in.addr[1:0] = 2'($urandom_range(1, 3));
        end
        default: begin in.flush = 1; in.re = 1'($urandom); in.ld = in.re; in.wer = 1; in.wef = 1; end
      endcase
      e = model(in);
      run_instr(in, o);
      n_cmp++;
      if (o.stalls !== e.stalls || o.reqs !== e.reqs || o.bus_bad !== 1'b0) begin
        n_err++; $display("FAIL rand%0d_timing: got stalls=%0d reqs=%0d bad=%0d expected %0d/%0d/0",
                          n, o.stalls, o.reqs, o.bus_bad, e.stalls, e.reqs);
      end
      n_cmp++;
      if (o.we_reg !== e.we_reg || o.we_freg !== e.we_freg || o.mis !== e.mis || o.merr !== e.merr) begin
        n_err++; $display("FAIL rand%0d_flags: got wer=%b wef=%b mis=%b merr=%b expected %b/%b/%b/%b",
                          n, o.we_reg, o.we_freg, o.mis, o.merr, e.we_reg, e.we_freg, e.mis, e.merr);
      end
      if (e.we_reg || e.we_freg) begin
        n_cmp++;
        if (o.rd !== e.rd || o.data !== e.data || o.f_inst !== e.f_inst) begin
          n_err++; $display("FAIL rand%0d_wb: got rd=%0d data=%h fi=%b expected %0d/%h/%b",
                            n, o.rd, o.data, o.f_inst, e.rd, e.data, e.f_inst);
        end
      end
      exp_merr = e.merr;
    end
  endtask

  task automatic test_reset_mid_access();
    ins_t in; obs_t o;
    drive_nop();
    RE_ex = 1; Load_ex = 1; WE_reg_ex = 1; rd_addr_ex = 5'd3; mem_addr_ex = 32'h40;
    @(negedge CLK);
    n_cmp++; if (dmem_bus.dmem_req !== 1'b1) begin n_err++; $display("FAIL mid_req_before: got %b expected 1", dmem_bus.dmem_req); end
    @(posedge CLK); #1;
    RST_N = 0;
    @(negedge CLK);
    n_cmp++;
    if (dmem_bus.dmem_req !== 1'b0 || Stall_mem !== 1'b0) begin
      n_err++; $display("FAIL mid_reset_drop: got req=%b stall=%b expected 0/0", dmem_bus.dmem_req, Stall_mem);
    end
    @(posedge CLK); #1;
    drive_nop();
    @(posedge CLK); #1;
    RST_N = 1;
    dmem_bus.dmem_rvalid = 1; dmem_bus.dmem_rdata = 32'hCAFEF00D;
    @(negedge CLK);
    n_cmp++;
    if (dmem_bus.dmem_req !== 1'b0 || Stall_mem !== 1'b0 || mem_err !== 1'b0 || WE_reg_mem !== 1'b0) begin
      n_err++; $display("FAIL mid_after_reset: got req=%b stall=%b merr=%b wer=%b expected 0/0/0/0",
                        dmem_bus.dmem_req, Stall_mem, mem_err, WE_reg_mem);
    end
    @(posedge CLK); #1;
    dmem_bus.dmem_rvalid = 0;
    exp_merr = 1'b0;
    in = blank(); in.re = 1; in.ld = 1; in.wer = 1; in.rd = 5'd12; in.addr = 32'h44;
    in.g = 0; in.rv = 1; in.rdata = 32'h0BADCAFE;
    run_instr(in, o);
    n_cmp++;
    if (o.stalls !== 1 || o.we_reg !== 1'b1 || o.data !== 32'h0BADCAFE || o.merr !== 1'b0) begin
      n_err++; $display("FAIL post_reset_load: got stalls=%0d we=%b data=%h merr=%b expected 1/1/0badcafe/0",
                        o.stalls, o.we_reg, o.data, o.merr);
    end
  endtask

  initial begin
    dmem_bus.dmem_gnt = 0; dmem_bus.dmem_rvalid = 0; dmem_bus.dmem_rdata = '0;
    test_reset();
    test_store();
    test_load_wait();
    test_alu_flush();
    test_misaligned();
    test_timeout();
    test_random();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
